load_store_unit: RTL

- Parametrised data-memory access unit between the pipeline MEM stage and the data-memory bus.
- Loads: byte/half/word (and dword when DATA_W=64), signed or unsigned, extended to DATA_W. Stores: lane-shifted data with per-byte enables.
- Accesses that cross a DATA_W boundary are split into two bus beats by an internal FSM, or trapped, selected by parameter.
- Little-endian: address offset 0 maps to bits [7:0].

---
 rtl/load_store_unit.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
// Data-memory access unit sitting between the MEM stage and the data bus.
// Loads byte/half/word (dword on a 64-bit bus), sign- or zero-extended to
// DATA_W. Stores are lane-shifted with per-byte enables. Accesses that cross
// a DATA_W boundary are either split into two bus beats or reported as an
// error, depending on SPLIT_MISALIGNED. Little-endian lane order.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_*              request from the pipeline (valid/ready)
//   mem_valid/ready    bus beat request channel (valid/ready)
//   mem_we/addr/be/wdata  beat attributes, stable while mem_valid && !mem_ready
//   mem_rvalid/rdata   read return, honoured only while waiting for it
//   rsp_valid/data/err one-cycle completion pulse with registered result
//
// Handshake rule: a transfer occurs on a rising clk edge where valid and
// ready are both high; the sender holds valid and its payload unchanged
// until that edge.
module load_store_unit #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter int SPLIT_MISALIGNED = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Latched request
    logic              r_we;
    logic              r_signed;
    logic [1:0]        r_size;
    logic [OFF_W-1:0]  r_off;
    logic [ADDR_W-1:0] r_base;
    logic [DATA_W-1:0] r_wdata;
    logic              r_beat;      // 0 = first beat, 1 = second beat of a split
    logic [DATA_W-1:0] r_rdata_lo;  // beat-0 read data of a split load
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    // Incoming request decode
    logic [OFF_W-1:0]  w_req_off;
    logic [3:0]        w_req_nbytes;
    logic [OFF_W-1:0]  w_req_low_mask;
    logic              w_req_misal;
    logic              w_req_illegal;

    // Latched request decode
    logic [3:0]          w_nbytes;
    logic [6:0]          w_nbits;
    logic                w_split;
    logic                w_more;       // a second beat still has to go out
    logic [2*BYTES-1:0]  w_be_wide;
    logic [2*DATA_W-1:0] w_wdata_wide;
    logic [DATA_W-1:0]   w_rd_lo;
    logic [DATA_W-1:0]   w_rd_hi;
    logic [DATA_W-1:0]   w_merged;
    logic                w_sign;
    logic [DATA_W-1:0]   w_ext;

    assign w_req_off      = req_addr[OFF_W-1:0];
    assign w_req_nbytes   = 4'd1 << req_size;
    assign w_req_low_mask = OFF_W'(w_req_nbytes - 4'd1);
    assign w_req_misal    = |(w_req_off & w_req_low_mask);
    assign w_req_illegal  = (w_req_nbytes > 4'(BYTES)) ||
                            ((SPLIT_MISALIGNED == 0) && w_req_misal);

    assign w_nbytes = 4'd1 << r_size;
    assign w_nbits  = {w_nbytes, 3'b000};
    assign w_split  = (int'(r_off) + int'(w_nbytes)) > BYTES;
    assign w_more   = !r_beat && w_split;

    // Lanes off..off+N-1 of a two-word window: low half is beat 0, high half beat 1.
    always_comb begin
        w_be_wide = '0;
        for (int i = 0; i < 2 * BYTES; i++) begin
            if ((i >= int'(r_off)) && (i < int'(r_off) + int'(w_nbytes))) begin
                w_be_wide[i] = 1'b1;
            end
        end
    end

    assign w_wdata_wide = {{DATA_W{1'b0}}, r_wdata} << {r_off, 3'b000};

    // Read merge: beat-1 data (if any) sits above beat-0 data, then the
    // window is shifted down by the byte offset.
    assign w_rd_lo  = r_beat ? r_rdata_lo : mem_rdata;
    assign w_rd_hi  = r_beat ? mem_rdata : '0;
    assign w_merged = DATA_W'({w_rd_hi, w_rd_lo} >> {r_off, 3'b000});

    // Extension from bit 8N-1; when N fills the bus nothing is extended.
    always_comb begin
        w_sign = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == int'(w_nbits) - 1) begin
                w_sign = w_merged[i];
            end
        end
        w_ext = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_ext[i] = (i < int'(w_nbits)) ? w_merged[i] : (r_signed & w_sign);
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next_state = w_req_illegal ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    if (!r_we) begin
                        w_next_state = S_WAIT;
                    end else if (w_more) begin
                        w_next_state = S_REQ;
                    end else begin
                        w_next_state = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_next_state = w_more ? S_REQ : S_RESP;
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= 2'd0;
            r_off      <= '0;
            r_base     <= '0;
            r_wdata    <= '0;
            r_beat     <= 1'b0;
            r_rdata_lo <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_signed   <= req_signed;
                        r_size     <= req_size;
                        r_off      <= w_req_off;
                        r_base     <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        r_wdata    <= req_wdata;
                        r_beat     <= 1'b0;
                        r_rsp_data <= '0;
                        r_rsp_err  <= w_req_illegal;
                    end
                end
                S_REQ: begin
                    if (mem_ready && r_we) begin
                        if (w_more) begin
                            r_beat <= 1'b1;
                        end else begin
                            r_rsp_data <= '0;
                            r_rsp_err  <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        if (w_more) begin
                            r_rdata_lo <= mem_rdata;
                            r_beat     <= 1'b1;
                        end else begin
                            r_rsp_data <= w_ext;
                            r_rsp_err  <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus outputs are decoded from the latched request, so they cannot move
    // while a beat is stalled, and read as zero whenever no beat is offered.
    assign req_ready = (r_state == S_IDLE);
    assign mem_valid = (r_state == S_REQ);
    assign mem_we    = mem_valid & r_we;
    assign mem_addr  = !mem_valid ? '0 :
                       (r_beat ? r_base + ADDR_W'(BYTES) : r_base);
    assign mem_be    = !mem_valid ? '0 :
                       (r_beat ? w_be_wide[2*BYTES-1:BYTES] : w_be_wide[BYTES-1:0]);
    assign mem_wdata = !(mem_valid && r_we) ? '0 :
                       (r_beat ? w_wdata_wide[2*DATA_W-1:DATA_W] : w_wdata_wide[DATA_W-1:0]);

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule
